// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: opcodes, FSM states,
// ALU / mux selector codes and the packed control vector driven onto the datapath.
package multicycle_ctrl_pkg;

    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h3;

    localparam logic [5:0] OP_J   = 6'd1;
    localparam logic [5:0] OP_BEQ = 6'd32;
    localparam logic [5:0] OP_BNE = 6'd33;
    localparam logic [5:0] OP_LWI = 6'd59;
    localparam logic [5:0] OP_SWI = 6'd60;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_ONE  = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_BOFF = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_RWB      = 4'd4,
        S_EXEC_I   = 4'd5,
        S_IWB      = 4'd6,
        S_BRANCH   = 4'd7,
        S_JUMP     = 4'd8,
        S_MEM_ADDR = 4'd9,
        S_MEM_RD   = 4'd10,
        S_MEM_WB   = 4'd11,
        S_MEM_WR   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       beq;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_src;
        logic [3:0] alu_op;
        logic [1:0] alu_src_b;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_rtype(input logic [5:0] op);
        return ((op >= 6'd16) && (op <= 6'd21)) || (op == 6'd23);
    endfunction

    function automatic logic is_itype(input logic [5:0] op);
        return ((op >= 6'd50) && (op <= 6'd53)) || (op == 6'd55) || (op == 6'd57);
    endfunction

    // Anything not dispatched out of DECODE retires there as a nop.
    function automatic logic is_dispatched(input logic [5:0] op);
        return (op == OP_J) || is_rtype(op) || (op == OP_BEQ) || (op == OP_BNE) ||
               is_itype(op) || (op == OP_LWI) || (op == OP_SWI);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decoder: maps the current state (plus latched opcode) to the
// datapath control vector. Live opcode is used only for the nop retire in DECODE.
module mc_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode_q,
    input  logic [5:0]  opcode,
    output ctrl_t       ctrl
);

    always_comb begin
        // NOTE: zeroing the whole vector first keeps every unlisted output at 0
        // and guarantees no latch is inferred for fields a state leaves untouched.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_BOFF;
                ctrl.alu_op     = ALU_ADD;
                ctrl.instr_done = !is_dispatched(opcode);
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = opcode_q[3:0];
            end
            S_RWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = opcode_q[3:0];
            end
            S_IWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.beq           = (opcode_q == OP_BEQ);
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_fsm_controller.sv
// Multicycle CPU controller: holds the FSM state and latched opcode, computes the
// next state, and drives the datapath control lines from mc_ctrl_decode.
module multicycle_fsm_controller
    import multicycle_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] OPcode,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       BEQ,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSrc,
    output logic [3:0] ALUOP,
    output logic [1:0] ALUSrcB,
    output logic       InstrDone
);

    state_t     state_q, state_d;
    logic [5:0] opcode_q;
    ctrl_t      ctrl;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous and wins over any transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_RST;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) opcode_q <= OPcode;
        end
    end

    always_comb begin
        state_d = S_RST;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (OPcode == OP_J)                              state_d = S_JUMP;
                else if (is_rtype(OPcode))                       state_d = S_EXEC_R;
                else if ((OPcode == OP_BEQ) || (OPcode == OP_BNE)) state_d = S_BRANCH;
                else if (is_itype(OPcode))                       state_d = S_EXEC_I;
                else if ((OPcode == OP_LWI) || (OPcode == OP_SWI)) state_d = S_MEM_ADDR;
                else                                             state_d = S_FETCH;
            end
            S_EXEC_R:   state_d = S_RWB;
            S_RWB:      state_d = S_FETCH;
            S_EXEC_I:   state_d = S_IWB;
            S_IWB:      state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_MEM_ADDR: state_d = (opcode_q == OP_LWI) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = S_FETCH;
            default:    state_d = S_RST;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state    (state_q),
        .opcode_q (opcode_q),
        .opcode   (OPcode),
        .ctrl     (ctrl)
    );

    assign PCWriteCond = ctrl.pc_write_cond;
    assign PCWrite     = ctrl.pc_write;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign BEQ         = ctrl.beq;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign PCSrc       = ctrl.pc_src;
    assign ALUOP       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign InstrDone   = ctrl.instr_done;

endmodule
